// File: rtl/sobel_window_ctrl_if.sv
// rtl/sobel_window_ctrl_if.sv - pixel/window handshake bundle between the Sobel window controller and its neighbours
interface sobel_window_ctrl_if #(
    parameter int CW = 7,
    parameter int RW = 7
);
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic          shift_en;
    logic [CW-1:0] col_addr;
    logic          win_valid;
    logic          out_ready;
    logic [RW-1:0] win_row;
    logic [CW-1:0] win_col;
    logic          busy;
    logic          frame_done;

    // master is the controller side; slave is the pixel source / Sobel consumer side
    modport master (
        input  start, in_valid, out_ready,
        output in_ready, shift_en, col_addr, win_valid, win_row, win_col, busy, frame_done
    );

    modport slave (
        output start, in_valid, out_ready,
        input  in_ready, shift_en, col_addr, win_valid, win_row, win_col, busy, frame_done
    );
endinterface

// File: rtl/sobel_window_ctrl.sv
// rtl/sobel_window_ctrl.sv - raster counters and 3x3 window valid tracking for a Sobel stage
module sobel_window_ctrl #(
    parameter int WIDTH  = 100,
    parameter int HEIGHT = 100,
    parameter int CW     = $clog2(WIDTH),
    parameter int RW     = $clog2(HEIGHT)
) (
    input  logic                clk,
    input  logic                rst,
    sobel_window_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          win_valid_q;
    logic [RW-1:0] win_row_q;
    logic [CW-1:0] win_col_q;

    logic in_ready;
    logic shift_en;
    logic last_pix;
    logic qualify;
    logic done;

    // a held window blocks new pixels so the window registers never slip under a stalled consumer
    assign in_ready = !rst && (state == RUN) && (!win_valid_q || bus.out_ready);
    assign shift_en = bus.in_valid && in_ready;
    assign last_pix = shift_en && (row == ROW_LAST) && (col == COL_LAST);
    assign qualify  = shift_en && (row >= RW'(2)) && (col >= CW'(2));

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_pix) state_nxt = FLUSH;
            FLUSH: begin
                done = !win_valid_q || bus.out_ready;
                if (done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (((state == IDLE) && bus.start) || last_pix) begin
            col <= '0;
            row <= '0;
        end else if (shift_en) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // centre lags the accepted pixel by one row and one column
    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
        end else if (qualify) begin
            win_valid_q <= 1'b1;
            win_row_q   <= row - RW'(1);
            win_col_q   <= col - CW'(1);
        end else if (bus.out_ready) begin
            win_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.shift_en   = shift_en;
    assign bus.col_addr   = col;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_row    = win_row_q;
    assign bus.win_col    = win_col_q;
    assign bus.busy       = !rst && (state != IDLE);
    assign bus.frame_done = done;
endmodule

// File: doc/sobel_window_ctrl.md
SOBEL_WINDOW_CTRL -- requirements
Module: sobel_window_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 100, image width in pixels (>=3).
REQ-002 SHALL have parameter HEIGHT, default 100, image height in pixels (>=3).
REQ-003 SHALL have parameter CW = $clog2(WIDTH), and parameter RW = $clog2(HEIGHT); column and row counter widths.
REQ-004 clk  in  1  sole clock; all logic on posedge clk.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle request to process one frame; honoured only in IDLE.
REQ-007 in_valid  in  1  upstream pixel available, raster order.
REQ-008 in_ready  out  1  controller accepts the pixel this cycle.
REQ-009 shift_en  out  1  shift strobe to the 3x3 window and line-buffer write enable.
REQ-010 col_addr  out  CW  column of the pixel being accepted; line-buffer address.
REQ-011 win_valid  out  1  the 3x3 window holds a complete, valid neighbourhood.
REQ-012 out_ready  in  1  downstream Sobel stage consumes the window this cycle.
REQ-013 win_row  out  RW  row of the window centre.
REQ-014 win_col  out  CW  column of the window centre.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 frame_done  out  1  one-cycle pulse when the last window of a frame has been consumed.

Function
REQ-017 SHALL implement the states IDLE, RUN and FLUSH.
REQ-018 IDLE->RUN on start; RUN->FLUSH on acceptance of pixel (HEIGHT-1, WIDTH-1); FLUSH->IDLE on the frame_done cycle.
REQ-019 start SHALL be ignored in RUN and FLUSH.
REQ-020 in_ready = (state==RUN) && (!win_valid || out_ready).
REQ-021 shift_en = in_valid && in_ready, purely combinational.
REQ-022 col_addr SHALL equal the current column counter.
REQ-023 Column and row counters SHALL hold unless shift_en is high.
REQ-024 On each shift_en, col SHALL increment; at WIDTH-1 it SHALL wrap to 0 and row SHALL increment.
REQ-025 Both counters SHALL clear to 0 on the RUN->FLUSH transition and on IDLE->RUN.
REQ-026 win_valid SHALL be set on the cycle after a shift_en that accepted pixel (r,c) with r>=2 and c>=2, i.e. latency 1, aligned with the window register update.
REQ-027 On that same edge, win_row SHALL be loaded with r-1 and win_col with c-1.
REQ-028 win_valid SHALL clear on out_ready when no new qualifying shift occurs in the same cycle; the registered window is held stable while win_valid && !out_ready.
REQ-029 A qualifying shift_en concurrent with out_ready SHALL keep win_valid high and load the new coordinates (back-to-back windows, full throughput).
REQ-030 Pixels with c<2 or r<2 SHALL be shifted but SHALL NOT raise win_valid; stale columns from the previous row are never exposed.
REQ-031 A frame SHALL produce exactly (WIDTH-2)*(HEIGHT-2) windows, in raster order of their centres.
REQ-032 In FLUSH, frame_done SHALL pulse on the cycle win_valid==0, or on the cycle win_valid && out_ready, whichever comes first; the state SHALL then return to IDLE.
REQ-033 start arriving in the frame_done cycle SHALL be ignored; start in the next cycle (IDLE) SHALL be honoured.

Reset
REQ-034 While rst is high, the state SHALL be IDLE, counters 0, and win_valid, win_row, win_col, frame_done all 0.
REQ-035 While rst is high, in_ready=0, shift_en=0 and busy=0; rst SHALL override start.
REQ-036 rst asserted mid-frame SHALL abandon the frame without a frame_done pulse; the next frame requires a new start.

Verification
REQ-037 WIDTH=4, HEIGHT=4, start, in_valid and out_ready held high, 16 pixels -> windows appear one cycle after pixels 10, 11, 14 and 15 are accepted, with centres (1,1), (1,2), (2,1) and (2,2); frame_done fires one cycle after the last window; busy then drops.
REQ-038 Same frame, out_ready low for 3 cycles while window (1,1) is valid -> in_ready=0 and shift_en=0 during the stall; win_row/win_col hold (1,1); no pixel is lost; 4 windows total.
REQ-039 in_valid toggling every other cycle -> counters advance only on shift_en; the window sequence is identical to REQ-037.
REQ-040 start pulsed during RUN, and again in the frame_done cycle -> both ignored; start one cycle later begins a new frame with col_addr=0.
REQ-041 rst asserted after 9 pixels accepted -> next cycle state is IDLE and all outputs are 0; no frame_done; a following start plus a full 16-pixel frame gives the REQ-037 result.
REQ-042 WIDTH=3, HEIGHT=3 boundary -> exactly one window, centre (1,1), after the 9th pixel.
